// File: rtl/npc_pc_unit_pkg.sv
// Shared definitions for the program-counter stage: next-PC select codes,
// FSM state encodings, the default reset PC and an alignment helper.
package npc_pc_unit_pkg;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JAL    = 2'b10;
    localparam logic [1:0] NPC_JALR   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        TRAP = 2'b10
    } pc_state_e;

    // A fetch target is usable only if it is word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/npc_pc_unit_if.sv
// Bus between the EX-stage branch judge / hazard unit and the PC stage.
// master = side that drives the EX-stage information, slave = the PC stage.
interface npc_pc_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [1:0]       npc_sel;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_imm;
    logic [31:0]      ex_rs1;
    logic             stall;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             fetch_valid;
    logic             kill_ifid;
    logic             kill_idex;
    logic [CNT_W-1:0] redirect_cnt;
    logic             misalign;

    modport master (
        output npc_sel, ex_valid, ex_pc, ex_imm, ex_rs1, stall,
        input  pc, pc_plus4, fetch_valid, kill_ifid, kill_idex, redirect_cnt, misalign
    );

    modport slave (
        input  npc_sel, ex_valid, ex_pc, ex_imm, ex_rs1, stall,
        output pc, pc_plus4, fetch_valid, kill_ifid, kill_idex, redirect_cnt, misalign
    );
endinterface

// File: rtl/npc_target_calc.sv
// Redirect target computation for the PC stage. Branch and jal add the
// immediate to the EX PC; jalr adds it to rs1 and clears bit 0. The
// alignment flag port exists only when PC_ALIGN_CHECK_EN is defined.
module npc_target_calc
    import npc_pc_unit_pkg::*;
(
    input  logic [1:0]  npc_sel,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
`ifdef PC_ALIGN_CHECK_EN
    output logic        misaligned,
`endif
    output logic [31:0] target
);

    // Select the adder operands by jump kind; sums wrap modulo 2^32
    always_comb begin
        target = ex_pc + ex_imm;
        case (npc_sel)
            NPC_BRANCH, NPC_JAL: target = ex_pc + ex_imm;
            NPC_JALR:            target = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
            default:             target = ex_pc + ex_imm;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(target);
`endif

endmodule

// File: rtl/npc_pc_unit.sv
// Program-counter stage: owns the fetch PC, the BOOT/RUN(/TRAP) FSM, the
// pipeline kill strobes and a saturating redirect counter.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned targets trap).
module npc_pc_unit
    import npc_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned CNT_W    = 32
) (
    input logic           clk,
    input logic           rst,
    npc_pc_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    pc_state_e        state_r;
    logic [31:0]      pc_r;
    logic [31:0]      pc_plus4_r;
    logic [CNT_W-1:0] cnt_r;
    logic             fetch_valid_r;
    logic [31:0]      target_s;
    logic             redirect_s;
    logic             kill_s;
`ifdef PC_ALIGN_CHECK_EN
    logic             misalign_r;
    logic             tgt_misaligned_s;
`endif

    npc_target_calc u_target_calc (
        .npc_sel    (bus.npc_sel),
        .ex_pc      (bus.ex_pc),
        .ex_imm     (bus.ex_imm),
        .ex_rs1     (bus.ex_rs1),
`ifdef PC_ALIGN_CHECK_EN
        .misaligned (tgt_misaligned_s),
`endif
        .target     (target_s)
    );

    assign redirect_s = bus.ex_valid & (bus.npc_sel != NPC_PLUS4);

    // Kill strobes: same-cycle redirect in RUN, held high while trapped
    always_comb begin
        kill_s = 1'b0;
        case (state_r)
            RUN:     kill_s = redirect_s;
`ifdef PC_ALIGN_CHECK_EN
            TRAP:    kill_s = 1'b1;
`endif
            default: kill_s = 1'b0;
        endcase
    end

    // FSM, PC register, redirect counter and sticky misalign flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= BOOT;
            pc_r          <= RESET_PC;
            pc_plus4_r    <= RESET_PC + 32'd4;
            cnt_r         <= CNT_ZERO;
            fetch_valid_r <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                // One cycle for the instruction memory read of RESET_PC
                BOOT: begin
                    state_r       <= RUN;
                    fetch_valid_r <= 1'b1;
                    pc_r          <= pc_plus4_r;
                    pc_plus4_r    <= pc_plus4_r + 32'd4;
                end
                RUN: begin
                    if (redirect_s) begin
`ifdef PC_ALIGN_CHECK_EN
                        if (tgt_misaligned_s) begin
                            state_r       <= TRAP;
                            fetch_valid_r <= 1'b0;
                            misalign_r    <= 1'b1;
                        end else begin
                            pc_r       <= target_s;
                            pc_plus4_r <= target_s + 32'd4;
                            cnt_r      <= (cnt_r != CNT_MAX) ? cnt_r + CNT_ONE : cnt_r;
                        end
`else
                        pc_r       <= target_s;
                        pc_plus4_r <= target_s + 32'd4;
                        cnt_r      <= (cnt_r != CNT_MAX) ? cnt_r + CNT_ONE : cnt_r;
`endif
                    end else if (!bus.stall) begin
                        pc_r       <= pc_plus4_r;
                        pc_plus4_r <= pc_plus4_r + 32'd4;
                    end else begin
                        pc_r       <= pc_r;
                        pc_plus4_r <= pc_plus4_r;
                    end
                end
`ifdef PC_ALIGN_CHECK_EN
                // Frozen until reset
                TRAP: begin
                    state_r <= TRAP;
                end
`endif
                default: begin
                    state_r       <= BOOT;
                    fetch_valid_r <= 1'b0;
                    pc_r          <= RESET_PC;
                    pc_plus4_r    <= RESET_PC + 32'd4;
                end
            endcase
        end
    end

    assign bus.pc           = pc_r;
    assign bus.pc_plus4     = pc_plus4_r;
    assign bus.fetch_valid  = fetch_valid_r;
    assign bus.kill_ifid    = kill_s;
    assign bus.kill_idex    = kill_s;
    assign bus.redirect_cnt = cnt_r;
`ifdef PC_ALIGN_CHECK_EN
    assign bus.misalign     = misalign_r;
`else
    assign bus.misalign     = 1'b0;
`endif

endmodule

// File: tb/tb_npc_pc_unit.sv
// Scoreboard bench for npc_pc_unit: directed cases plus random traffic,
// expectations from a behavioural PC model, checked on the falling edge.
module tb_npc_pc_unit;

    localparam int unsigned CNT_W    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_SAT  = (1 << CNT_W) - 1;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        fv;
        logic        kill;
        logic [31:0] cnt;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // behavioural model state
    logic [31:0] m_pc   = RESET_PC;
    bit          m_boot = 1'b1;
    bit          m_trap = 1'b0;
    int          m_cnt  = 0;

    npc_pc_unit_if #(.CNT_W(CNT_W)) bus ();

    npc_pc_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: async-reset check when rst rises mid-cycle, else pop and compare
    always @(negedge clk or posedge rst) begin
        if (clk === 1'b1) begin
            #1;
            chk("async_rst_pc",  bus.pc, RESET_PC);
            chk("async_rst_pc4", bus.pc_plus4, RESET_PC + 32'd4);
            chk("async_rst_fv",  {31'd0, bus.fetch_valid}, 32'd0);
            chk("async_rst_cnt", 32'(bus.redirect_cnt), 32'd0);
            chk("async_rst_kil", {30'd0, bus.kill_ifid, bus.kill_idex}, 32'd0);
            chk("async_rst_mis", {31'd0, bus.misalign}, 32'd0);
        end else if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("pc",        bus.pc, e.pc);
            chk("pc_plus4",  bus.pc_plus4, e.pc4);
            chk("fetch_vld", {31'd0, bus.fetch_valid}, {31'd0, e.fv});
            chk("kill_ifid", {31'd0, bus.kill_ifid}, {31'd0, e.kill});
            chk("kill_idex", {31'd0, bus.kill_idex}, {31'd0, e.kill});
            chk("redir_cnt", 32'(bus.redirect_cnt), e.cnt);
            chk("misalign",  {31'd0, bus.misalign}, {31'd0, e.mis});
        end
    end

    // Push the expectation for the current cycle, then advance the model
    task automatic step();
        exp_t        e;
        bit          redir;
        logic [31:0] tgt;
        redir  = !m_boot && !m_trap && (bus.ex_valid === 1'b1) && (bus.npc_sel != 2'b00);
        e.pc   = m_pc;
        e.pc4  = m_pc + 32'd4;
        e.fv   = !m_boot && !m_trap;
        e.kill = m_trap || redir;
        e.cnt  = 32'(m_cnt);
        e.mis  = m_trap;
        sb_q.push_back(e);
        if (m_boot) begin
            m_boot = 1'b0;
            m_pc   = m_pc + 32'd4;
        end else if (m_trap) begin
            m_pc = m_pc;
        end else if (redir) begin
            if (bus.npc_sel == 2'b11) tgt = (bus.ex_rs1 + bus.ex_imm) & 32'hFFFF_FFFE;
            else                      tgt = bus.ex_pc + bus.ex_imm;
            if (ALIGN_CHK && (tgt % 4 != 0)) begin
                m_trap = 1'b1;
            end else begin
                m_pc  = tgt;
                m_cnt = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
            end
        end else if (!bus.stall) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic set_in(input logic v, input logic [1:0] sel, input logic [31:0] epc,
                          input logic [31:0] imm, input logic [31:0] rs1, input logic st);
        bus.ex_valid = v;
        bus.npc_sel  = sel;
        bus.ex_pc    = epc;
        bus.ex_imm   = imm;
        bus.ex_rs1   = rs1;
        bus.stall    = st;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] epc,
                         input logic [31:0] imm, input logic [31:0] rs1, input logic st);
        @(posedge clk);
        #1;
        set_in(v, sel, epc, imm, rs1, st);
        step();
    endtask

    task automatic push_reset_vals();
        exp_t e;
        e.pc   = RESET_PC;
        e.pc4  = RESET_PC + 32'd4;
        e.fv   = 1'b0;
        e.kill = 1'b0;
        e.cnt  = 32'd0;
        e.mis  = 1'b0;
        sb_q.push_back(e);
    endtask

    // Assert reset mid-cycle, hold for n cycles, release into the BOOT cycle
    task automatic apply_reset(input int n);
        @(posedge clk);
        #1;
        set_in(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b1;
        push_reset_vals();
        repeat (n - 1) begin
            @(posedge clk);
            #1;
            push_reset_vals();
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_pc   = RESET_PC;
        m_boot = 1'b1;
        m_trap = 1'b0;
        m_cnt  = 0;
        step();
    endtask

    task automatic rand_traffic(input int n);
        repeat (n) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                  $urandom, 1'($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        set_in(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        apply_reset(2);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        // taken branch with negative offset
        drive(1'b1, 2'b01, 32'h0000_0100, 32'hFFFF_FFF0, 32'd0, 1'b0);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        // jal to 0x40, then stall there for 3 cycles
        drive(1'b1, 2'b10, 32'h0000_0030, 32'h0000_0010, 32'd0, 1'b0);
        repeat (3) drive(1'b1, 2'b00, 32'd0, 32'd0, 32'd0, 1'b1);
        // redirect wins over stall
        drive(1'b1, 2'b10, 32'h0000_003C, 32'h0000_0020, 32'd0, 1'b1);
        // ex_valid low masks a select
        drive(1'b0, 2'b01, 32'h0000_1000, 32'h0000_0100, 32'd0, 1'b0);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        // 17 back-to-back redirects saturate the counter
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 2'b01, $urandom & 32'hFFFF_FFFC, 32'h0000_0010, 32'd0, 1'b0);
        end
        drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        rand_traffic(150);
        // asynchronous reset mid-stream
        apply_reset(1);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        // jalr with odd sum: bit 0 cleared, bit 1 left for the alignment check
        drive(1'b1, 2'b11, 32'd0, 32'h0000_0004, 32'h0000_2003, 1'b0);
        repeat (3) drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        rand_traffic(100);
        apply_reset(1);
        rand_traffic(60);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/npc_pc_unit.md
# npc_pc_unit

Program-counter stage of the pipelined RV32I core, directly downstream of the EX-stage branch judge. Consumes the 2-bit next-PC select and the flush request, computes the redirect target, and owns the PC register that drives instruction fetch. Also produces the IF/ID and ID/EX kill strobes, a fetch-valid qualifier, and a saturating redirect counter for performance measurement.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the redirect counter.
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- npc_sel  in  2  from branch judge: 00 PC+4, 01 taken branch, 10 jal, 11 jalr.
- ex_valid  in  1  EX stage holds a real instruction; npc_sel is ignored when low.
- ex_pc  in  32  PC of the instruction in EX.
- ex_imm  in  32  sign-extended immediate of the EX instruction.
- ex_rs1  in  32  forwarded rs1 value of the EX instruction (jalr base).
- stall  in  1  load-use hazard hold from the hazard unit.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, for the IF/ID register.
- fetch_valid  out  1  instruction fetched at pc is to be used.
- kill_ifid  out  1  invalidate the IF/ID register at the next edge.
- kill_idex  out  1  invalidate the ID/EX register at the next edge.
- redirect_cnt  out  CNT_W  number of accepted redirects, saturating.
- misalign  out  1  sticky misaligned-target flag (see Configuration).

## Operation
- redirect = ex_valid & (npc_sel != 00).
- Target: 01 and 10 use ex_pc + ex_imm. 11 uses (ex_rs1 + ex_imm) & ~32'h1. Arithmetic is 32-bit modulo 2^32; carries are dropped and wrap is silent.
- Next PC priority: TRAP hold > redirect > stall hold > pc + 4.
- Redirect with simultaneous stall: the redirect wins. PC loads the target, and both kills assert (the stalled ID instruction is on the wrong path).
- kill_ifid = kill_idex = redirect (combinational, same cycle). When there is no redirect, stall alone does not kill IF/ID. The hazard unit bubbles ID/EX itself.
- FSM states:
  - BOOT (reset state): fetch_valid = 0, PC holds RESET_PC, moves to RUN after one cycle. This covers the synchronous instruction-memory read latency.
  - RUN: normal operation, fetch_valid = 1.
  - TRAP (only with the macro): PC frozen, fetch_valid = 0, kills held high. Leaves only on rst.
- In BOOT, redirect and stall inputs are ignored.
- redirect_cnt increments by 1 on every accepted redirect in RUN and saturates at all-ones.

## Timing
- Reset values: pc = RESET_PC, pc_plus4 = RESET_PC + 4, fetch_valid = 0, kill_ifid = kill_idex = 0, redirect_cnt = 0, misalign = 0, state = BOOT.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous). Release is followed by one BOOT cycle.
- Redirect seen in cycle N: pc = target in cycle N+1. Kills are high during cycle N only, so the branch penalty is 2 cycles.
- Stall in cycle N without redirect: pc in N+1 equals pc in N.
- redirect_cnt reflects the redirect of cycle N in cycle N+1.

## Configuration
- Macro PC_ALIGN_CHECK_EN.
- Defined: a redirect whose target has bits[1:0] != 00 moves to TRAP, sets misalign, and does not load pc.
- Undefined: no check is made, the target is loaded as-is, misalign is tied 0, and the TRAP state is not built.

## Structure
- Shared package/header holds:
  - NPC select encodings (NPC_PLUS4 = 2'b00, NPC_BRANCH = 2'b01, NPC_JAL = 2'b10, NPC_JALR = 2'b11);
  - FSM state encodings (BOOT, RUN, TRAP);
  - the default reset PC constant.
- One sub-module, npc_target_calc: combinational adder and select producing the target and the alignment flag. The PC register, FSM and counter stay in npc_pc_unit.

## Test plan
- Reset, then release: pc = 0 and fetch_valid = 0 for one cycle, then pc = 4 with fetch_valid = 1.
- ex_valid = 1, npc_sel = 01, ex_pc = 0x100, ex_imm = 0xFFFFFFF0: kills high that cycle, next pc = 0xF0, redirect_cnt = 1.
- npc_sel = 11, ex_rs1 = 0x2003, ex_imm = 0x4: next pc = 0x2006 (bit0 cleared). With PC_ALIGN_CHECK_EN defined: misalign = 1, pc frozen, fetch_valid = 0.
- stall = 1 with npc_sel = 00 for 3 cycles at pc = 0x40: pc holds 0x40 and kills stay low. Then stall = 1 together with npc_sel = 10, ex_pc = 0x3C, ex_imm = 0x20: next pc = 0x5C and both kills high.
- ex_valid = 0 with npc_sel = 01: no kill, pc increments by 4, counter unchanged.
- CNT_W = 4, 17 consecutive redirects: redirect_cnt saturates at 0xF. Asserting rst mid-stream returns pc to RESET_PC and the counter to 0 asynchronously.
